// File: rtl/scheduler_pkg.sv
// scheduler_pkg: data-interface types shared by the scheduler and its delay line.
package scheduler_pkg;
  typedef logic [7:0] thread_id_t;
  typedef union packed {
    logic [3:0][31:0] u32;
    logic [127:0]     raw;
  } return_data_t;
  typedef struct packed {
    return_data_t data;
    thread_id_t   receive_id;
    logic         valid;
  } read_return_t;
  function automatic thread_id_t sat_dec(input thread_id_t v);
    return (v == '0) ? '0 : v - 8'd1;
  endfunction
endpackage

// File: rtl/return_delay_line.sv
// return_delay_line: shift register that delays read returns; invalid returns enter as all-zero.
module return_delay_line
  import scheduler_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  read_return_t i_data,
  output logic         o_tap_valid,
  output thread_id_t   o_tap_id,
  output read_return_t o_out
);
  read_return_t r_buf [DEPTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_buf[DEPTH-1] <= i_data.valid ? i_data : '0;
      for (int i = 0; i < DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
    end
  end
  assign o_tap_valid = r_buf[1].valid;
  assign o_tap_id    = r_buf[1].receive_id;
  assign o_out       = r_buf[0];
endmodule

// File: rtl/scheduler.sv
// scheduler: picks one thread per cycle to fetch, returned-data threads ahead of the waiting queue,
// and issues operate one cycle after the request.
module scheduler
  import scheduler_pkg::*;
#(
  parameter int RETURN_DELAY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         halt,
  input  read_return_t data_return,
  output read_return_t data_deliver,
  output logic         operate,
  input  thread_id_t   waiting_thread_count,
  input  thread_id_t   waiting_next_id,
  input  thread_id_t   waiting_next_id2,
  output logic         requesting_thread,
  output thread_id_t   requested_thread_id
);
  logic         w_tap_valid;
  thread_id_t   w_tap_id;
  read_return_t w_out;
  logic         r_last_q_issue;
  thread_id_t   w_eff_count;
  thread_id_t   w_eff_head;
  logic         w_q_issue;
  return_delay_line #(.DEPTH(RETURN_DELAY)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .i_data     (data_return),
    .o_tap_valid(w_tap_valid),
    .o_tap_id   (w_tap_id),
    .o_out      (w_out)
  );
  // queue inputs still show the thread popped last cycle, so skip past it
  assign w_eff_count = r_last_q_issue ? sat_dec(waiting_thread_count) : waiting_thread_count;
  assign w_eff_head  = r_last_q_issue ? waiting_next_id2 : waiting_next_id;
  assign w_q_issue   = !w_tap_valid && !halt && (w_eff_count != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      requesting_thread   <= 1'b0;
      requested_thread_id <= '0;
      r_last_q_issue      <= 1'b0;
      operate             <= 1'b0;
      data_deliver        <= '0;
    end else begin
      requesting_thread   <= w_tap_valid | w_q_issue;
      requested_thread_id <= w_tap_valid ? w_tap_id : (w_q_issue ? w_eff_head : '0);
      r_last_q_issue      <= w_q_issue;
      operate             <= requesting_thread;
      data_deliver        <= w_out;
    end
  end
endmodule

// File: tb/tb_scheduler.sv
// tb_scheduler: randomized and directed stimulus against an edge-indexed reference model,
// with a scoreboard monitor checking requests and operate beats.
module tb_scheduler;
  import scheduler_pkg::*;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt = 1'b1;
  read_return_t data_return = '0;
  read_return_t data_deliver;
  logic         operate;
  thread_id_t   waiting_thread_count = '0;
  thread_id_t   waiting_next_id = '0;
  thread_id_t   waiting_next_id2 = '0;
  logic         requesting_thread;
  thread_id_t   requested_thread_id;

  scheduler #(.RETURN_DELAY(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .halt                (halt),
    .data_return         (data_return),
    .data_deliver        (data_deliver),
    .operate             (operate),
    .waiting_thread_count(waiting_thread_count),
    .waiting_next_id     (waiting_next_id),
    .waiting_next_id2    (waiting_next_id2),
    .requesting_thread   (requesting_thread),
    .requested_thread_id (requested_thread_id)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; thread_id_t id; } req_exp_t;
  typedef struct { int cyc; read_return_t d; } op_exp_t;
  req_exp_t     rq[$];
  op_exp_t      oq[$];
  req_exp_t     mr;
  op_exp_t      mo;
  int           checks = 0;
  int           failures = 0;
  int           edge_cnt = 0;
  bit           m_qflag = 0;
  read_return_t m_ret[int];
  read_return_t z = '0;
  read_return_t r;

  always @(posedge clk) if (!rst) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a return sampled on edge e requests on edge e+2 and operates on e+3;
  // otherwise the queue issues when unhalted and threads remain that were not just popped.
  task automatic drive(input logic h, input read_return_t rr, input thread_id_t c, input thread_id_t n1, input thread_id_t n2);
    int e;
    thread_id_t ec, eh;
    halt = h;
    data_return = rr;
    waiting_thread_count = c;
    waiting_next_id = n1;
    waiting_next_id2 = n2;
    e = edge_cnt + 1;
    if (rr.valid) m_ret[e] = rr;
    ec = m_qflag ? ((c == 0) ? 8'd0 : c - 8'd1) : c;
    eh = m_qflag ? n2 : n1;
    if (m_ret.exists(e - 2)) begin
      rq.push_back('{e, m_ret[e-2].receive_id});
      oq.push_back('{e + 1, m_ret[e-2]});
      m_qflag = 0;
    end else if (!h && ec != 0) begin
      rq.push_back('{e, eh});
      oq.push_back('{e + 1, z});
      m_qflag = 1;
    end else begin
      m_qflag = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ret.delete();
    m_qflag = 0;
    rq.delete();
    oq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (requesting_thread || (rq.size() > 0 && rq[0].cyc == edge_cnt)) begin
        if (rq.size() == 0 || rq[0].cyc != edge_cnt) begin
          failures++;
          $display("FAIL req_unexpected: edge %0d got id=%0d expected no request", edge_cnt, requested_thread_id);
        end else begin
          mr = rq.pop_front();
          if (!requesting_thread || requested_thread_id != mr.id) begin
            failures++;
            $display("FAIL req: edge %0d got req=%0b id=%0d expected req=1 id=%0d", edge_cnt, requesting_thread, requested_thread_id, mr.id);
          end
        end
      end else if (requested_thread_id != '0) begin
        failures++;
        $display("FAIL idle_id: edge %0d got id=%0d expected 0", edge_cnt, requested_thread_id);
      end
      checks++;
      if (operate || (oq.size() > 0 && oq[0].cyc == edge_cnt)) begin
        if (oq.size() == 0 || oq[0].cyc != edge_cnt) begin
          failures++;
          $display("FAIL op_unexpected: edge %0d got operate=1 expected 0", edge_cnt);
        end else begin
          mo = oq.pop_front();
          if (!operate || data_deliver != mo.d) begin
            failures++;
            $display("FAIL op: edge %0d got op=%0b data=%h expected op=1 data=%h", edge_cnt, operate, data_deliver, mo.d);
          end
        end
      end else if (data_deliver != '0) begin
        failures++;
        $display("FAIL idle_data: edge %0d got %h expected 0", edge_cnt, data_deliver);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req", 137'(requesting_thread), 137'(0));
    chk("reset_op", 137'(operate), 137'(0));
    chk("reset_data", data_deliver, 137'(0));
    // single read return while halted
    r = '0;
    r.valid = 1'b1;
    r.receive_id = 8'd15;
    r.data.u32[1] = 32'd32;
    drive(1, r, 0, 0, 0);
    repeat (5) drive(1, z, 0, 0, 0);
    // halt gating with stale queue inputs
    drive(1, z, 1, 15, 0);
    drive(1, z, 1, 15, 0);
    drive(0, z, 1, 15, 0);
    drive(0, z, 1, 15, 0);
    repeat (3) drive(1, z, 0, 0, 0);
    // back-to-back queue issue
    drive(0, z, 2, 56, 65);
    drive(0, z, 2, 56, 65);
    drive(0, z, 1, 65, 0);
    repeat (3) drive(1, z, 0, 0, 0);
    // returned data collides with a queue issue
    r.receive_id = 8'd33;
    r.data.u32[3] = 32'hdead_beef;
    drive(1, r, 0, 0, 0);
    drive(1, z, 0, 0, 0);
    drive(0, z, 1, 40, 0);
    drive(0, z, 1, 40, 0);
    repeat (3) drive(1, z, 0, 0, 0);
    // reset flushes in-flight returns
    drive(1, r, 0, 0, 0);
    do_reset();
    repeat (5) drive(1, z, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r = '0;
      r.data.raw = {$urandom, $urandom, $urandom, $urandom};
      r.receive_id = 8'($urandom);
      r.valid = ($urandom_range(0, 2) == 0);
      if (n == 200) do_reset();
      drive($urandom_range(0, 3) == 0, r, 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    repeat (6) drive(1, z, 0, 0, 0);
    chk("drain_req", 137'(rq.size()), 137'(0));
    chk("drain_op", 137'(oq.size()), 137'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
